// File: rtl/cmd_fifo_if.sv
// Command FIFO bundle: dispatcher write side, UART transmitter pop side and status.
// The FIFO takes the slave modport; whoever drives and observes it takes master.
interface cmd_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              cmd_fifo_rd_en;
  logic [DATA_W-1:0] cmd_fifo_rd_data;
  logic              cmd_fifo_valid;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport slave (
    input  wr_en, wr_data, cmd_fifo_rd_en,
    output full, cmd_fifo_rd_data, cmd_fifo_valid, count, overflow, underflow
  );

  modport master (
    output wr_en, wr_data, cmd_fifo_rd_en,
    input  full, cmd_fifo_rd_data, cmd_fifo_valid, count, overflow, underflow
  );
endinterface

// File: rtl/cmd_fifo.sv
// First-word-fall-through command FIFO between the command dispatcher and the UART
// transmitter, with sticky overflow/underflow flags.
module cmd_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic     clk,
  input  logic     rst,
  cmd_fifo_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              valid, full, pop_acc, wr_acc;

  // Status flags come straight off the count register so they always agree with it.
  assign valid   = (count_q != '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  // A pop frees a slot in the same cycle, so a full FIFO can still accept a write.
  assign pop_acc = bus.cmd_fifo_rd_en && valid;
  assign wr_acc  = bus.wr_en && (!full || pop_acc);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q  | (bus.wr_en && !wr_acc);
    underflow_d = underflow_q | (bus.cmd_fifo_rd_en && !valid);
    if (wr_acc)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_acc) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (wr_acc && !pop_acc)      count_d = count_q + CNT_W'(1);
    else if (pop_acc && !wr_acc) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not cleared by reset; the pointers alone define what is live.
  always_ff @(posedge clk) begin
    if (rst && wr_acc) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  // Asynchronous read of the head entry gives the fall-through behaviour.
  assign bus.cmd_fifo_rd_data = mem_q[rd_ptr_q];
  assign bus.cmd_fifo_valid   = valid;
  assign bus.full             = full;
  assign bus.count            = count_q;
  assign bus.overflow         = overflow_q;
  assign bus.underflow        = underflow_q;
endmodule

// File: tb/tb_cmd_fifo.sv
// Directed and reference-queue checks for cmd_fifo at DATA_W=8, DEPTH=16.
module tb_cmd_fifo;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  cmd_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();
  cmd_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en          = 1'b0;
    bus.wr_data        = '0;
    bus.cmd_fifo_rd_en = 1'b0;
  endtask

  task automatic drive(input logic w, input logic [7:0] d, input logic r);
    bus.wr_en          = w;
    bus.wr_data        = d;
    bus.cmd_fifo_rd_en = r;
    tick();
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  logic [7:0] q [$];
  bit         ovf_m, unf_m;

  initial begin
    idle();
    do_reset();
    $display("reset: initial state");
    check_eq("rst_count", bus.count, 0);
    check_eq("rst_valid", bus.cmd_fifo_valid, 0);
    check_eq("rst_full", bus.full, 0);
    check_eq("rst_ovf", bus.overflow, 0);
    check_eq("rst_unf", bus.underflow, 0);

    $display("txn: write 41,42,43");
    drive(1, 8'h41, 0);
    check_eq("w1_valid", bus.cmd_fifo_valid, 1);
    check_eq("w1_data", bus.cmd_fifo_rd_data, 8'h41);
    check_eq("w1_count", bus.count, 1);
    drive(1, 8'h42, 0);
    drive(1, 8'h43, 0);
    check_eq("w3_count", bus.count, 3);
    check_eq("w3_data", bus.cmd_fifo_rd_data, 8'h41);

    $display("txn: fill 00..0F, overflow write FF, drain");
    do_reset();
    for (int i = 0; i < DEPTH; i++) drive(1, 8'(i), 0);
    check_eq("fill_full", bus.full, 1);
    check_eq("fill_count", bus.count, DEPTH);
    check_eq("fill_ovf0", bus.overflow, 0);
    drive(1, 8'hFF, 0);
    check_eq("ovf_set", bus.overflow, 1);
    check_eq("ovf_count", bus.count, DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      check_eq("drain_data", bus.cmd_fifo_rd_data, i);
      drive(0, 8'h00, 1);
    end
    check_eq("drain_valid", bus.cmd_fifo_valid, 0);
    check_eq("drain_count", bus.count, 0);
    check_eq("drain_unf", bus.underflow, 0);
    check_eq("ovf_sticky", bus.overflow, 1);

    $display("txn: full with simultaneous write AA and pop for 20 cycles");
    do_reset();
    for (int i = 0; i < DEPTH; i++) drive(1, 8'(8'h10 + i), 0);
    for (int i = 0; i < 20; i++) begin
      check_eq("fwp_data", bus.cmd_fifo_rd_data, (i < DEPTH) ? (8'h10 + i) : 8'hAA);
      drive(1, 8'hAA, 1);
      check_eq("fwp_count", bus.count, DEPTH);
      check_eq("fwp_ovf", bus.overflow, 0);
    end
    check_eq("fwp_full", bus.full, 1);

    $display("txn: empty with write 55 and pop together");
    do_reset();
    drive(1, 8'h55, 1);
    check_eq("ewp_unf", bus.underflow, 1);
    check_eq("ewp_count", bus.count, 1);
    check_eq("ewp_data", bus.cmd_fifo_rd_data, 8'h55);

    $display("txn: pop on empty, load 5, reset mid-operation, write 99");
    do_reset();
    drive(0, 8'h00, 1);
    check_eq("pe_unf", bus.underflow, 1);
    check_eq("pe_count", bus.count, 0);
    for (int i = 0; i < 5; i++) drive(1, 8'(8'h60 + i), 0);
    check_eq("l5_count", bus.count, 5);
    bus.wr_en = 1'b1; bus.wr_data = 8'h77; bus.cmd_fifo_rd_en = 1'b1;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    idle();
    check_eq("mr_count", bus.count, 0);
    check_eq("mr_valid", bus.cmd_fifo_valid, 0);
    check_eq("mr_full", bus.full, 0);
    check_eq("mr_unf", bus.underflow, 0);
    check_eq("mr_ovf", bus.overflow, 0);
    drive(1, 8'h99, 0);
    check_eq("mr_data", bus.cmd_fifo_rd_data, 8'h99);
    check_eq("mr_count1", bus.count, 1);

    $display("txn: random traffic 10000 cycles");
    do_reset();
    q.delete();
    ovf_m = 0;
    unf_m = 0;
    for (int c = 0; c < 10000; c++) begin
      int   phase, pw, pr;
      bit   w, r, pop_ok, wr_ok, was_empty;
      logic [7:0] d;
      phase     = (c / 500) % 3;
      pw        = (phase == 0) ? 80 : ((phase == 1) ? 25 : 55);
      pr        = (phase == 0) ? 25 : ((phase == 1) ? 80 : 50);
      w         = ($urandom_range(0, 99) < pw);
      r         = ($urandom_range(0, 99) < pr);
      d         = 8'($urandom_range(0, 255));
      was_empty = (q.size() == 0);
      pop_ok    = r && !was_empty;
      wr_ok     = w && (q.size() < DEPTH || pop_ok);
      if (pop_ok) begin
        check_eq("rnd_data", bus.cmd_fifo_rd_data, q[0]);
        void'(q.pop_front());
      end
      if (w && !wr_ok) ovf_m = 1;
      if (r && was_empty) unf_m = 1;
      if (wr_ok) q.push_back(d);
      drive(w, d, r);
      check_eq("rnd_count", bus.count, q.size());
      check_eq("rnd_cnt_le", (bus.count <= DEPTH), 1);
    end
    check_eq("rnd_ovf", bus.overflow, ovf_m);
    check_eq("rnd_unf", bus.underflow, unf_m);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cmd_fifo.md
CMD_FIFO -- requirements
Module: cmd_fifo

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the command byte width.
REQ-002 Parameter DEPTH, default 16, SHALL set the entry count; it SHALL be a power of two and at least 2.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-low reset.
REQ-005 wr_en  input  1  SHALL be the write request from the command dispatcher.
REQ-006 wr_data  input  DATA_W  SHALL be the byte written when wr_en is accepted.
REQ-007 full  output  1  SHALL be high when count equals DEPTH.
REQ-008 cmd_fifo_rd_en  input  1  SHALL be the pop request from the UART transmitter.
REQ-009 cmd_fifo_rd_data  output  DATA_W  SHALL present the oldest stored byte (first-word-fall-through).
REQ-010 cmd_fifo_valid  output  1  SHALL be high when count is nonzero.
REQ-011 count  output  $clog2(DEPTH)+1  SHALL report the number of stored entries, 0 to DEPTH.
REQ-012 overflow  output  1  SHALL be a sticky flag for a write refused by the FIFO.
REQ-013 underflow  output  1  SHALL be a sticky flag for a pop requested while empty.

Function
REQ-014 Write acceptance: wr_en high and (full low or a pop accepted the same cycle); data stored at wr_ptr, wr_ptr increments.
REQ-015 Pop acceptance: cmd_fifo_rd_en high and cmd_fifo_valid high; rd_ptr increments.
REQ-016 Pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0 with no gap or lost entry.
REQ-017 count SHALL update on each edge: +1 for a write only, -1 for a pop only, unchanged for both or neither.
REQ-018 Latency: a write accepted at edge N into an empty FIFO SHALL make cmd_fifo_valid high and cmd_fifo_rd_data equal that byte immediately after edge N.
REQ-019 After a pop at edge N with count>1, cmd_fifo_rd_data SHALL show the next entry immediately after edge N.
REQ-020 cmd_fifo_rd_data SHALL be stable while cmd_fifo_valid is high and no pop is accepted; its value while cmd_fifo_valid is low is unspecified.
REQ-021 Full with simultaneous write and pop: both accepted, count stays DEPTH, overflow unchanged.
REQ-022 Full with write and no pop: write discarded, storage unchanged, overflow set next edge.
REQ-023 Empty with simultaneous write and pop: write accepted, pop ignored (no same-cycle bypass), underflow set, count becomes 1.
REQ-024 Empty with pop only: no state change except underflow set next edge.
REQ-025 overflow and underflow SHALL remain set until reset.
REQ-026 full, cmd_fifo_valid and count SHALL be registered-consistent: all derived from the same post-edge count.

Reset
REQ-027 On a clk edge with rst low: wr_ptr, rd_ptr, count SHALL become 0; full, cmd_fifo_valid, overflow, underflow SHALL become 0.
REQ-028 Reset SHALL take priority over any simultaneous wr_en or cmd_fifo_rd_en; storage contents need not be cleared.
REQ-029 Reset mid-operation (FIFO partially full) SHALL discard all entries; the first post-reset write SHALL be the first byte read.

Verification
REQ-030 Write 0x41, 0x42, 0x43, no pops -> cmd_fifo_valid high one edge after first write, cmd_fifo_rd_data=0x41, count=3.
REQ-031 Fill DEPTH=16 with 0x00..0x0F, write 0xFF with no pop -> full=1, overflow=1, 16 pops return 0x00..0x0F in order, then cmd_fifo_valid=0.
REQ-032 From full, assert wr_en (0xAA) and cmd_fifo_rd_en together for 20 cycles -> count stays 16, overflow stays 0, pop order intact across pointer wrap.
REQ-033 Empty FIFO, wr_en 0x55 with cmd_fifo_rd_en in same cycle -> underflow=1, count=1, cmd_fifo_rd_data=0x55 next cycle.
REQ-034 Load 5 entries, drive rst low one edge -> count=0, cmd_fifo_valid=0, flags 0; write 0x99 -> cmd_fifo_rd_data=0x99.
REQ-035 Random wr_en/cmd_fifo_rd_en traffic 10,000 cycles against a reference queue -> every popped byte matches, count never exceeds 16.
